// File: rtl/aclock_pkg.sv
// Shared types and limits for the Aclock core and its user-interface controller.
package aclock_pkg;

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_T_HR  = 3'd1,
        S_T_MIN = 3'd2,
        S_A_HR  = 3'd3,
        S_A_MIN = 3'd4
    } edit_state_e;

    localparam logic [2:0] ST_RUN   = S_RUN;
    localparam logic [2:0] ST_T_HR  = S_T_HR;
    localparam logic [2:0] ST_T_MIN = S_T_MIN;
    localparam logic [2:0] ST_A_HR  = S_A_HR;
    localparam logic [2:0] ST_A_MIN = S_A_MIN;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_time_t;

endpackage

// File: rtl/aclock_ui_ctrl_if.sv
// Button front-end / core-facing signal bundle of the alarm-clock UI controller.
interface aclock_ui_ctrl_if;
    import aclock_pkg::*;

    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_snooze;
    logic       btn_off;
    logic [1:0] cur_H1;
    logic [3:0] cur_H0;
    logic [3:0] cur_M1;
    logic [3:0] cur_M0;
    logic       Alarm;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       AL_ON;
    logic       buzz;
    logic [2:0] edit_state;
    logic       blink;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_snooze, btn_off,
        output cur_H1, cur_H0, cur_M1, cur_M0, Alarm,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, STOP_al, AL_ON, buzz, edit_state, blink
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_snooze, btn_off,
        input  cur_H1, cur_H0, cur_M1, cur_M0, Alarm,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, STOP_al, AL_ON, buzz, edit_state, blink
    );

endinterface

// File: rtl/bcd_time_inc.sv
// BCD hour (00..23) and minute (00..59) increment with wrap; minutes never carry into hours.
module bcd_time_inc
    import aclock_pkg::*;
(
    input  bcd_time_t t,
    output bcd_time_t hr_inc,
    output bcd_time_t min_inc
);

    localparam logic [1:0] HR_T  = 2'(HR_MAX / 10);
    localparam logic [3:0] HR_U  = 4'(HR_MAX % 10);
    localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);

    always_comb begin
        hr_inc = t;
        if (t.h1 == HR_T && t.h0 == HR_U) begin
            hr_inc.h1 = '0;
            hr_inc.h0 = '0;
        end else if (t.h0 == 4'd9) begin
            hr_inc.h1 = t.h1 + 2'd1;
            hr_inc.h0 = '0;
        end else begin
            hr_inc.h0 = t.h0 + 4'd1;
        end

        min_inc = t;
        if (t.m0 == 4'd9) begin
            min_inc.m0 = '0;
            min_inc.m1 = (t.m1 == MIN_T) ? 4'd0 : t.m1 + 4'd1;
        end else begin
            min_inc.m0 = t.m0 + 4'd1;
        end
    end

endmodule

// File: rtl/aclock_ui_ctrl.sv
// Alarm-clock UI sequencer: edit FSM, load/stop strobes, snooze scheduler, edit timeout.
//   state | meaning
//   RUN   | normal display, inc toggles alarm enable
//   T_HR  | editing time hours       T_MIN | editing time minutes
//   A_HR  | editing alarm hours      A_MIN | editing alarm minutes
module aclock_ui_ctrl
    import aclock_pkg::*;
#(
    parameter int LD_CYCLES   = 1,
    parameter int SNOOZE_SEC  = 300,
    parameter int TIMEOUT_SEC = 30
) (
    input logic           clk,
    input logic           reset,
    aclock_ui_ctrl_if.slave ui
);

    localparam int SW = $clog2(LD_CYCLES + 1);
    localparam int NW = $clog2(SNOOZE_SEC + 1);
    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    logic [2:0]    state, state_nx;
    bcd_time_t     edit, shadow, cur, hr_nx, min_nx;
    logic          al_on, rebuzz, blink;
    logic [SW-1:0] stb_cnt;
    logic          f_time, f_alarm, f_stop;
    logic          snz_run;
    logic [NW-1:0] snz_cnt;
    logic [TW-1:0] idle_cnt;

    logic busy, any_btn, buzz, stop_ev, mode_ok, inc_ok;
    logic ld_time_ev, ld_al_ev, editing, timeout, win_end, hr_state;

    assign cur = {ui.cur_H1, ui.cur_H0, ui.cur_M1, ui.cur_M0};

    bcd_time_inc u_inc (
        .t       (edit),
        .hr_inc  (hr_nx),
        .min_inc (min_nx)
    );

    assign busy       = (stb_cnt != '0);
    assign any_btn    = ui.btn_mode | ui.btn_inc | ui.btn_snooze | ui.btn_off;
    assign buzz       = ui.Alarm | rebuzz;
    assign stop_ev    = ui.btn_off | (ui.btn_snooze & buzz);
    // Edits are frozen while any strobe runs so the core loads a stable value.
    assign mode_ok    = ui.btn_mode & ~busy;
    assign inc_ok     = ui.btn_inc & ~ui.btn_mode & ~busy;
    assign ld_time_ev = mode_ok & (state == ST_T_MIN);
    assign ld_al_ev   = mode_ok & (state == ST_A_MIN);
    assign editing    = (state != ST_RUN);
    assign hr_state   = (state == ST_T_HR) | (state == ST_A_HR);
    assign timeout    = editing & ui.tick_1hz & ~any_btn & (idle_cnt == TW'(TIMEOUT_SEC - 1));
    assign win_end    = busy & (stb_cnt == SW'(1)) & ~stop_ev;

    always_comb begin
        state_nx = state;
        if (mode_ok) begin
            case (state)
                ST_RUN:   state_nx = ST_T_HR;
                ST_T_HR:  state_nx = ST_T_MIN;
                ST_T_MIN: state_nx = ST_A_HR;
                ST_A_HR:  state_nx = ST_A_MIN;
                default:  state_nx = ST_RUN;
            endcase
        end else if (timeout) begin
            state_nx = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            edit     <= '0;
            shadow   <= '0;
            al_on    <= 1'b0;
            blink    <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state <= state_nx;
            if (mode_ok && state == ST_RUN)
                edit <= cur;
            else if (inc_ok && hr_state)
                edit <= hr_nx;
            else if (inc_ok && editing)
                edit <= min_nx;
            else if (timeout || (win_end && f_time))
                edit <= shadow;

            if (ld_al_ev) begin
                shadow <= edit;
                al_on  <= 1'b1;
            end else if (inc_ok && !editing) begin
                al_on  <= ~al_on;
            end

            if (state_nx == ST_RUN)
                blink <= 1'b0;
            else if (ui.tick_1hz)
                blink <= ~blink;

            if (!editing || any_btn || timeout)
                idle_cnt <= '0;
            else if (ui.tick_1hz)
                idle_cnt <= idle_cnt + TW'(1);
        end
    end

    // One shared window; a stop arriving mid-window restarts it and keeps earlier kinds asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stb_cnt <= '0;
            f_time  <= 1'b0;
            f_alarm <= 1'b0;
            f_stop  <= 1'b0;
        end else if (stop_ev || ld_time_ev || ld_al_ev) begin
            stb_cnt <= SW'(LD_CYCLES);
            f_time  <= f_time  | ld_time_ev;
            f_alarm <= f_alarm | ld_al_ev;
            f_stop  <= f_stop  | stop_ev;
        end else if (busy) begin
            stb_cnt <= stb_cnt - SW'(1);
            if (win_end) begin
                f_time  <= 1'b0;
                f_alarm <= 1'b0;
                f_stop  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ui.btn_off) begin
            rebuzz  <= 1'b0;
            snz_run <= 1'b0;
            snz_cnt <= '0;
        end else if (ui.btn_snooze && buzz) begin
            rebuzz  <= 1'b0;
            snz_run <= 1'b1;
            snz_cnt <= '0;
        end else if (snz_run && ui.tick_1hz) begin
            if (snz_cnt == NW'(SNOOZE_SEC - 1)) begin
                rebuzz  <= 1'b1;
                snz_run <= 1'b0;
                snz_cnt <= '0;
            end else begin
                snz_cnt <= snz_cnt + NW'(1);
            end
        end
    end

    assign ui.H_in1      = edit.h1;
    assign ui.H_in0      = edit.h0;
    assign ui.M_in1      = edit.m1;
    assign ui.M_in0      = edit.m0;
    assign ui.LD_time    = f_time;
    assign ui.LD_alarm   = f_alarm;
    assign ui.STOP_al    = f_stop;
    assign ui.AL_ON      = al_on;
    assign ui.buzz       = buzz;
    assign ui.edit_state = state;
    assign ui.blink      = blink;

endmodule

// File: tb/tb_aclock_ui_ctrl.sv
// Randomized bench for aclock_ui_ctrl against an integer-arithmetic behavioural model.
module tb_aclock_ui_ctrl;

    localparam int LDC = 2;
    localparam int SNZ = 300;
    localparam int TMO = 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aclock_ui_ctrl_if ui();

    aclock_ui_ctrl #(.LD_CYCLES(LDC), .SNOOZE_SEC(SNZ), .TIMEOUT_SEC(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .ui    (ui)
    );

    int n_vec = 0;
    int n_err = 0;

    // model state: times as plain integers, snooze as ticks remaining
    int m_state, m_h, m_m, m_sh_h, m_sh_m, m_snz_left, m_idle, m_s_left;
    bit m_al_on, m_rebuzz, m_blink, k_time, k_al, k_stop;
    bit checking = 1'b0;
    int cur_h = 0, cur_m = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int dut_hm();
        return int'(ui.H_in1) * 1000 + int'(ui.H_in0) * 100 + int'(ui.M_in1) * 10 + int'(ui.M_in0);
    endfunction

    task automatic set_cur(int h, int m);
        cur_h = h;
        cur_m = m;
        ui.cur_H1 = 2'(h / 10);
        ui.cur_H0 = 4'(h % 10);
        ui.cur_M1 = 4'(m / 10);
        ui.cur_M0 = 4'(m % 10);
    endtask

    task automatic model_step();
        bit mode, inc, snz, off, tick, anyb, busy, buzz_now, stop_ev, lt_ev, la_ev;
        int old;
        if (reset) begin
            m_state = 0; m_h = 0; m_m = 0; m_sh_h = 0; m_sh_m = 0;
            m_snz_left = 0; m_idle = 0; m_s_left = 0;
            m_al_on = 0; m_rebuzz = 0; m_blink = 0;
            k_time = 0; k_al = 0; k_stop = 0;
            checking = 1'b1;
            return;
        end
        mode = ui.btn_mode; inc = ui.btn_inc; snz = ui.btn_snooze; off = ui.btn_off;
        tick = ui.tick_1hz;
        anyb = mode | inc | snz | off;
        busy = (m_s_left > 0);
        buzz_now = ui.Alarm | m_rebuzz;
        stop_ev = off | (snz & buzz_now);
        lt_ev = 0; la_ev = 0;
        old = m_state;

        if (off) begin
            m_rebuzz = 0; m_snz_left = 0;
        end else if (snz && buzz_now) begin
            m_rebuzz = 0; m_snz_left = SNZ;
        end else if (m_snz_left > 0 && tick) begin
            m_snz_left--;
            if (m_snz_left == 0) m_rebuzz = 1;
        end

        if (!busy && mode) begin
            case (old)
                0: begin m_h = cur_h; m_m = cur_m; end
                2: lt_ev = 1;
                4: begin m_sh_h = m_h; m_sh_m = m_m; la_ev = 1; m_al_on = 1; end
                default: ;
            endcase
            m_state = (old + 1) % 5;
        end else if (!busy && inc) begin
            if (old == 0) m_al_on = !m_al_on;
            else if (old == 1 || old == 3) m_h = (m_h + 1) % 24;
            else m_m = (m_m + 1) % 60;
        end

        if (old != 0 && tick && !anyb) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_state = 0; m_h = m_sh_h; m_m = m_sh_m;
            end
        end
        if (anyb || m_state == 0) m_idle = 0;

        if (stop_ev || lt_ev || la_ev) begin
            m_s_left = LDC;
            k_time |= lt_ev; k_al |= la_ev; k_stop |= stop_ev;
        end else if (m_s_left > 0) begin
            m_s_left--;
            if (m_s_left == 0) begin
                if (k_time) begin m_h = m_sh_h; m_m = m_sh_m; end
                k_time = 0; k_al = 0; k_stop = 0;
            end
        end

        if (m_state == 0) m_blink = 0;
        else if (tick) m_blink = !m_blink;
    endtask

    task automatic compare();
        chk("edit_state", 32'(ui.edit_state), 32'(m_state));
        chk("H_in1", 32'(ui.H_in1), 32'(m_h / 10));
        chk("H_in0", 32'(ui.H_in0), 32'(m_h % 10));
        chk("M_in1", 32'(ui.M_in1), 32'(m_m / 10));
        chk("M_in0", 32'(ui.M_in0), 32'(m_m % 10));
        chk("LD_time", 32'(ui.LD_time), 32'(k_time));
        chk("LD_alarm", 32'(ui.LD_alarm), 32'(k_al));
        chk("STOP_al", 32'(ui.STOP_al), 32'(k_stop));
        chk("AL_ON", 32'(ui.AL_ON), 32'(m_al_on));
        chk("buzz", 32'(ui.buzz), 32'(ui.Alarm | m_rebuzz));
        chk("blink", 32'(ui.blink), 32'(m_blink));
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (checking) compare();
    end

    task automatic step(bit mode = 0, bit inc = 0, bit snz = 0, bit off = 0, bit tick = 0);
        ui.btn_mode = mode; ui.btn_inc = inc; ui.btn_snooze = snz; ui.btn_off = off;
        ui.tick_1hz = tick;
        @(negedge clk);
        ui.btn_mode = 0; ui.btn_inc = 0; ui.btn_snooze = 0; ui.btn_off = 0;
        ui.tick_1hz = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit quiet;
        ui.btn_mode = 0; ui.btn_inc = 0; ui.btn_snooze = 0; ui.btn_off = 0;
        ui.tick_1hz = 0; ui.Alarm = 0;
        set_cur(0, 0);
        repeat (3) @(negedge clk);
        chk("lit_reset_state", 32'(ui.edit_state), 0);
        chk("lit_reset_hm", 32'(dut_hm()), 0);
        chk("lit_reset_alon", 32'(ui.AL_ON), 0);
        chk("lit_reset_ld", 32'({ui.LD_time, ui.LD_alarm, ui.STOP_al}), 0);
        reset = 1'b0;

        // time set 03:02
        step(.mode(1));
        repeat (3) step(.inc(1));
        step(.mode(1));
        repeat (2) step(.inc(1));
        step(.mode(1));
        chk("lit_ldtime_rise", 32'(ui.LD_time), 1);
        chk("lit_ldtime_hm", 32'(dut_hm()), 302);
        chk("lit_ldtime_state", 32'(ui.edit_state), 3);
        step();
        chk("lit_ldtime_hold", 32'(ui.LD_time), 1);
        chk("lit_ldtime_hold_hm", 32'(dut_hm()), 302);
        step();
        chk("lit_ldtime_fall", 32'(ui.LD_time), 0);
        chk("lit_shadow_load", 32'(dut_hm()), 0);

        // wrap boundaries
        do_reset();
        set_cur(23, 59);
        step(.mode(1));
        chk("lit_load_cur", 32'(dut_hm()), 2359);
        step(.inc(1));
        chk("lit_hr_wrap", 32'(dut_hm()), 59);
        step(.mode(1));
        step(.inc(1));
        chk("lit_min_wrap", 32'(dut_hm()), 0);

        // alarm 07:30
        do_reset();
        set_cur(0, 0);
        repeat (3) step(.mode(1));
        repeat (2) step();
        repeat (7) step(.inc(1));
        step(.mode(1));
        repeat (30) step(.inc(1));
        step(.mode(1));
        chk("lit_ldalarm", 32'(ui.LD_alarm), 1);
        chk("lit_ldalarm_hm", 32'(dut_hm()), 730);
        chk("lit_alon", 32'(ui.AL_ON), 1);
        chk("lit_back_run", 32'(ui.edit_state), 0);
        repeat (2) step();

        // edit timeout
        set_cur(10, 0);
        step(.mode(1));
        step(.inc(1));
        chk("lit_to_inc", 32'(dut_hm()), 1100);
        repeat (TMO - 1) step(.tick(1));
        chk("lit_to_before", 32'(ui.edit_state), 1);
        step(.tick(1));
        chk("lit_to_state", 32'(ui.edit_state), 0);
        chk("lit_to_revert", 32'(dut_hm()), 730);
        chk("lit_to_nostrobe", 32'(ui.LD_time), 0);

        // snooze and off
        ui.Alarm = 1;
        step();
        chk("lit_buzz_alarm", 32'(ui.buzz), 1);
        step(.snz(1));
        ui.Alarm = 0;
        #1;
        chk("lit_snz_stop", 32'(ui.STOP_al), 1);
        chk("lit_snz_quiet", 32'(ui.buzz), 0);
        repeat (SNZ - 1) step(.tick(1));
        chk("lit_snz_before", 32'(ui.buzz), 0);
        step(.tick(1));
        chk("lit_rebuzz", 32'(ui.buzz), 1);
        step(.off(1));
        chk("lit_off_stop", 32'(ui.STOP_al), 1);
        chk("lit_off_quiet", 32'(ui.buzz), 0);
        repeat (2) step();

        // mode beats inc
        set_cur(5, 5);
        step(.mode(1), .inc(1));
        chk("lit_mi_state", 32'(ui.edit_state), 1);
        chk("lit_mi_hm", 32'(dut_hm()), 505);
        chk("lit_mi_alon", 32'(ui.AL_ON), 1);
        step(.mode(1), .inc(1));
        chk("lit_mi_hm2", 32'(dut_hm()), 505);

        // reset during strobe
        step(.mode(1));
        chk("lit_rs_strobe", 32'(ui.LD_time), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("lit_rs_ld", 32'(ui.LD_time), 0);
        chk("lit_rs_state", 32'(ui.edit_state), 0);
        chk("lit_rs_hm", 32'(dut_hm()), 0);
        chk("lit_rs_alon", 32'(ui.AL_ON), 0);
        reset = 1'b0;

        // randomized traffic alternating busy and quiet windows
        for (int i = 0; i < 20000; i++) begin
            quiet = ((i / 256) % 2) == 1;
            if (quiet) begin
                ui.btn_mode   = ($urandom_range(149) == 0);
                ui.btn_inc    = ($urandom_range(149) == 0);
                ui.btn_snooze = ($urandom_range(1499) == 0);
                ui.btn_off    = ($urandom_range(1499) == 0);
            end else begin
                ui.btn_mode   = ($urandom_range(5) == 0);
                ui.btn_inc    = ($urandom_range(5) == 0);
                ui.btn_snooze = ($urandom_range(39) == 0);
                ui.btn_off    = ($urandom_range(39) == 0);
            end
            ui.tick_1hz = ($urandom_range(1) == 0);
            if ($urandom_range(299) == 0) ui.Alarm = ~ui.Alarm;
            if ($urandom_range(63) == 0) set_cur(int'($urandom_range(23)), int'($urandom_range(59)));
            reset = ($urandom_range(3999) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        ui.btn_mode = 0; ui.btn_inc = 0; ui.btn_snooze = 0; ui.btn_off = 0; ui.tick_1hz = 0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
